// File: rtl/aes_core_sched.sv
// Round-robin scheduler sharing one iterative AES-128 core between two requesters.
// Captures a command, starts the core, waits under a watchdog and returns the result.
module aes_core_sched #(
  parameter int DATA_W  = 128,
  parameter int KEY_W   = 128,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [KEY_W-1:0]  req0_key,
  input  logic [DATA_W-1:0] req0_data,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic [DATA_W-1:0] resp0_data,
  output logic              resp0_err,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [KEY_W-1:0]  req1_key,
  input  logic [DATA_W-1:0] req1_data,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] resp1_data,
  output logic              resp1_err,
  output logic              core_start,
  output logic [KEY_W-1:0]  core_key,
  output logic [DATA_W-1:0] core_din,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_dout,
  output logic              busy,
  output logic              owner,
  output logic [7:0]        err_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rerr_q, rerr_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              start_q, start_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic              gnt0_s, gnt1_s, resp_rdy_s;

  // On a tie the requester that did not own the last grant wins.
  assign gnt1_s     = req1_valid && (!req0_valid || !owner_q);
  assign gnt0_s     = req0_valid && !gnt1_s;
  assign req0_ready = (state_q == ST_IDLE) && gnt0_s;
  assign req1_ready = (state_q == ST_IDLE) && gnt1_s;
  assign resp_rdy_s = owner_q ? resp1_ready : resp0_ready;

  assign core_start  = start_q;
  assign core_key    = key_q;
  assign core_din    = din_q;
  assign resp0_valid = rvalid_q[0];
  assign resp1_valid = rvalid_q[1];
  assign resp0_data  = rdata_q;
  assign resp1_data  = rdata_q;
  assign resp0_err   = rerr_q;
  assign resp1_err   = rerr_q;
  assign busy        = (state_q != ST_IDLE);
  assign owner       = owner_q;
  assign err_cnt     = err_cnt_q;

  // Next-state, capture and watchdog logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    key_d     = key_q;
    din_d     = din_q;
    rdata_d   = rdata_q;
    rerr_d    = rerr_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt0_s) begin
          key_d   = req0_key;
          din_d   = req0_data;
          owner_d = 1'b0;
          state_d = ST_ISSUE;
        end else if (gnt1_s) begin
          key_d   = req1_key;
          din_d   = req1_data;
          owner_d = 1'b1;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (core_done) begin
          rdata_d = core_dout;
          rerr_d  = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rdata_d   = {DATA_W{1'b0}};
          rerr_d    = 1'b1;
          err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
          state_d   = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (resp_rdy_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    start_d  = (state_d == ST_ISSUE);
    rvalid_d = {(state_d == ST_RESP) && owner_d, (state_d == ST_RESP) && !owner_d};
  end

  // State and output registers; owner resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      owner_q   <= 1'b1;
      key_q     <= {KEY_W{1'b0}};
      din_q     <= {DATA_W{1'b0}};
      rdata_q   <= {DATA_W{1'b0}};
      rerr_q    <= 1'b0;
      err_cnt_q <= 8'd0;
      start_q   <= 1'b0;
      rvalid_q  <= 2'b00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      key_q     <= key_d;
      din_q     <= din_d;
      rdata_q   <= rdata_d;
      rerr_q    <= rerr_d;
      err_cnt_q <= err_cnt_d;
      start_q   <= start_d;
      rvalid_q  <= rvalid_d;
    end
  end

endmodule

// File: tb/tb_aes_core_sched.sv
// Self-checking bench for aes_core_sched: behavioural AES core stand-in,
// scoreboard on request/response handshakes, table-driven ops and corner sequences.
module tb_aes_core_sched;

  localparam int TIMEOUT = 64;
  localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         ACLK = 1'b0;
  logic         ARESETN = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [127:0] req0_key = '0, req0_data = '0, req1_key = '0, req1_data = '0;
  logic         resp0_valid, resp1_valid;
  logic         resp0_ready = 1'b1, resp1_ready = 1'b1;
  logic [127:0] resp0_data, resp1_data;
  logic         resp0_err, resp1_err;
  logic         core_start, core_done;
  logic [127:0] core_key, core_din, core_dout;
  logic         busy, owner;
  logic [7:0]   err_cnt;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;
  int exp_errs = 0;

  aes_core_sched #(.DATA_W(128), .KEY_W(128), .TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_key(req0_key), .req0_data(req0_data),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data), .resp0_err(resp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_key(req1_key), .req1_data(req1_data),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data), .resp1_err(resp1_err),
    .core_start(core_start), .core_key(core_key), .core_din(core_din),
    .core_done(core_done), .core_dout(core_dout),
    .busy(busy), .owner(owner), .err_cnt(err_cnt)
  );

  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] d);
    if (k == K0 && d == P0) return C0;
    return d ^ {k[63:0], k[127:64]} ^ 128'ha5a5_5a5a_0f0f_f0f0_3c3c_c3c3_9696_6969;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail(input string name);
    chk_cnt++;
    $display("FAIL %s: bound expired, got no event expected one (cycle %0d)", name, cyc);
  endtask

  // Behavioural core: done pulse core_lat cycles after start unless hung.
  int           core_lat  = 41;
  bit           core_hang = 1'b0;
  int           rem = 0;
  logic         model_done = 1'b0, spur_done = 1'b0;
  logic [127:0] model_dout = '0, lk = '0, ld = '0;
  assign core_done = model_done | spur_done;
  assign core_dout = model_dout;

  always @(posedge ACLK) begin
    if (!ARESETN) begin
      rem <= 0; model_done <= 1'b0; model_dout <= '0;
    end else if (core_start && !core_hang) begin
      rem <= core_lat - 1; model_done <= 1'b0; lk <= core_key; ld <= core_din;
    end else if (rem == 1) begin
      rem <= 0; model_done <= 1'b1; model_dout <= core_fn(lk, ld);
    end else begin
      model_done <= 1'b0;
      if (rem > 1) rem <= rem - 1;
    end
  end

  // Scoreboard: expectation pushed on request handshake, checked on response handshake.
  typedef struct {bit id; logic [127:0] data; logic err;} sb_t;
  sb_t sb_q[$];

  task automatic sb_push(input bit id, input logic [127:0] k, input logic [127:0] d);
    sb_t e;
    bit to;
    to = core_hang || (core_lat > TIMEOUT);
    e.id = id;
    e.data = to ? 128'd0 : core_fn(k, d);
    e.err = to;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input bit id, input logic [127:0] d, input logic e_err);
    sb_t e;
    if (sb_q.size() == 0) begin
      chk("sb_unexpected_resp", {127'd0, id}, 128'hdead);
    end else begin
      e = sb_q.pop_front();
      chk("sb_owner", {127'd0, id}, {127'd0, e.id});
      chk("sb_data", d, e.data);
      chk("sb_err", {127'd0, e_err}, {127'd0, e.err});
    end
  endtask

  always @(negedge ACLK) begin
    #2;
    if (ARESETN) begin
      if (req0_valid && req0_ready) sb_push(1'b0, req0_key, req0_data);
      if (req1_valid && req1_ready) sb_push(1'b1, req1_key, req1_data);
      if (resp0_valid && resp0_ready) sb_check(1'b0, resp0_data, resp0_err);
      if (resp1_valid && resp1_ready) sb_check(1'b1, resp1_data, resp1_err);
      if (resp0_valid && resp1_valid) chk("both_resp_valid", 128'd1, 128'd0);
    end
  end

  // Starts at a falling edge; returns at the falling edge after the handshake.
  task automatic send_req(input bit id, input logic [127:0] k, input logic [127:0] d, output int t_acc);
    t_acc = -1;
    if (id == 1'b0) begin req0_valid = 1'b1; req0_key = k; req0_data = d; end
    else begin req1_valid = 1'b1; req1_key = k; req1_data = d; end
    for (int i = 0; i < 200 && t_acc < 0; i++) begin
      #1;
      if ((id == 1'b0 && req0_ready) || (id == 1'b1 && req1_ready)) t_acc = cyc;
      @(negedge ACLK);
    end
    if (id == 1'b0) req0_valid = 1'b0; else req1_valid = 1'b0;
    if (t_acc < 0) fail("req_accept");
  endtask

  task automatic wait_resp(input bit id, input int t_acc, input int exp_lat,
                           input logic [127:0] exp_d, input logic exp_e);
    int t_resp;
    bit other;
    t_resp = -1;
    other = 1'b0;
    #1;
    chk("core_start_T+1", {127'd0, core_start}, 128'd1);
    for (int i = 0; i < 200; i++) begin
      if ((id == 1'b0 && resp0_valid) || (id == 1'b1 && resp1_valid)) begin
        t_resp = cyc;
        break;
      end
      if ((id == 1'b0 && resp1_valid) || (id == 1'b1 && resp0_valid)) other = 1'b1;
      @(negedge ACLK); #1;
    end
    if (t_resp < 0) fail("resp_valid");
    else begin
      chk("resp_latency", 128'(t_resp - t_acc), 128'(exp_lat));
      chk("resp_data", (id == 1'b0) ? resp0_data : resp1_data, exp_d);
      chk("resp_err", {127'd0, (id == 1'b0) ? resp0_err : resp1_err}, {127'd0, exp_e});
    end
    chk("other_resp_quiet", {127'd0, other}, 128'd0);
  endtask

  typedef struct {
    bit id; logic [127:0] key; logic [127:0] data; logic [127:0] exp_data;
    logic exp_err; int lat; bit hang; int exp_lat;
  } op_t;

  function automatic op_t mk(input bit id, input logic [127:0] k, input logic [127:0] d,
                             input logic [127:0] ed, input logic ee, input int lat,
                             input bit hang, input int el);
    op_t o;
    o.id = id; o.key = k; o.data = d; o.exp_data = ed; o.exp_err = ee;
    o.lat = lat; o.hang = hang; o.exp_lat = el;
    return o;
  endfunction

  task automatic do_op(input op_t o);
    int t;
    core_lat = o.lat;
    core_hang = o.hang;
    send_req(o.id, o.key, o.data, t);
    if (t >= 0) begin
      wait_resp(o.id, t, o.exp_lat, o.exp_data, o.exp_err);
      if (o.exp_err) exp_errs = (exp_errs == 255) ? 255 : exp_errs + 1;
      chk("err_cnt", {120'd0, err_cnt}, 128'(exp_errs));
      @(negedge ACLK); #1;
      chk("idle_after_resp", {127'd0, busy}, 128'd0);
      @(negedge ACLK);
    end
  endtask

  op_t tbl[6];
  logic [127:0] kx, dx, hold_d;
  logic hold_e;
  bit bad, got;
  int t;

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    kx = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    dx = 128'h3243f6a8885a308d313198a2e0370734;
    tbl[0] = mk(1'b0, K0, P0, C0, 1'b0, 41, 1'b0, 43);
    tbl[1] = mk(1'b1, kx, dx, core_fn(kx, dx), 1'b0, 41, 1'b0, 43);
    tbl[2] = mk(1'b0, ~kx, dx, core_fn(~kx, dx), 1'b0, 64, 1'b0, 66);
    tbl[3] = mk(1'b1, kx, ~dx, core_fn(kx, ~dx), 1'b0, 2, 1'b0, 4);
    tbl[4] = mk(1'b0, K0, dx, 128'd0, 1'b1, 0, 1'b1, 66);
    tbl[5] = mk(1'b1, ~K0, P0, core_fn(~K0, P0), 1'b0, 63, 1'b0, 65);

    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;
    #1;
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_owner", {127'd0, owner}, 128'd1);
    chk("rst_valids", {126'd0, resp1_valid, resp0_valid}, 128'd0);
    chk("rst_start", {127'd0, core_start}, 128'd0);
    chk("rst_err_cnt", {120'd0, err_cnt}, 128'd0);
    chk("rst_core_key", core_key, 128'd0);
    chk("rst_ready", {126'd0, req1_ready, req0_ready}, 128'd0);
    @(negedge ACLK);

    // Both requesters held valid from reset: grants must alternate 0,1,0,1.
    req0_valid = 1'b1; req0_key = K0; req0_data = P0;
    req1_valid = 1'b1; req1_key = kx; req1_data = dx;
    for (int op = 0; op < 4; op++) begin
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
        #1;
        if (req0_ready || req1_ready) begin got = 1'b1; break; end
        @(negedge ACLK);
      end
      if (!got) fail("rr_grant");
      else begin
        chk("rr_grant", {127'd0, req1_ready}, 128'(op % 2));
        chk("rr_onehot", {127'd0, req0_ready & req1_ready}, 128'd0);
      end
      @(negedge ACLK);
      if (op == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      #1;
      chk("rr_owner", {127'd0, owner}, 128'(op % 2));
    end
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge ACLK); #1;
      if (!busy) begin got = 1'b1; break; end
    end
    if (!got) fail("rr_drain");
    @(negedge ACLK);

    for (int i = 0; i < 6; i++) do_op(tbl[i]);

    // Backpressure on requester 1 while requester 0 is waiting.
    core_lat = 41; core_hang = 1'b0;
    resp1_ready = 1'b0;
    send_req(1'b1, kx, P0, t);
    wait_resp(1'b1, t, 43, core_fn(kx, P0), 1'b0);
    hold_d = resp1_data; hold_e = resp1_err;
    req0_valid = 1'b1; req0_key = K0; req0_data = P0;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK); #1;
      if (resp1_data !== hold_d || resp1_err !== hold_e || !busy || req0_ready || !resp1_valid) bad = 1'b1;
    end
    chk("bp_hold", {127'd0, bad}, 128'd0);
    resp1_ready = 1'b1;
    @(negedge ACLK); #1;
    chk("bp_req0_ready_after", {127'd0, req0_ready}, 128'd1);
    chk("bp_resp1_dropped", {127'd0, resp1_valid}, 128'd0);
    t = cyc;
    @(negedge ACLK);
    req0_valid = 1'b0;
    wait_resp(1'b0, t, 43, C0, 1'b0);
    @(negedge ACLK); @(negedge ACLK);

    // Spurious core_done in IDLE must be ignored.
    spur_done = 1'b1;
    @(negedge ACLK);
    spur_done = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (busy || resp0_valid || resp1_valid || core_start) bad = 1'b1;
      @(negedge ACLK);
    end
    chk("spurious_done_ignored", {127'd0, bad}, 128'd0);

    // One-cycle reset in the middle of WAIT abandons the operation.
    send_req(1'b0, K0, P0, t);
    repeat (10) @(negedge ACLK);
    ARESETN = 1'b0;
    @(negedge ACLK);
    ARESETN = 1'b1;
    sb_q.delete();
    exp_errs = 0;
    #1;
    chk("mid_rst_busy", {127'd0, busy}, 128'd0);
    chk("mid_rst_owner", {127'd0, owner}, 128'd1);
    chk("mid_rst_valids", {126'd0, resp1_valid, resp0_valid}, 128'd0);
    chk("mid_rst_start", {127'd0, core_start}, 128'd0);
    chk("mid_rst_err_cnt", {120'd0, err_cnt}, 128'd0);
    bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge ACLK); #1;
      if (resp0_valid || resp1_valid || busy) bad = 1'b1;
    end
    chk("mid_rst_no_resp", {127'd0, bad}, 128'd0);
    @(negedge ACLK);

    // Watchdog: first timeout gives err_cnt=1, then saturation at 255.
    do_op(mk(1'b0, K0, P0, 128'd0, 1'b1, 0, 1'b1, 66));
    for (int i = 0; i < 255; i++) do_op(mk(i[0], kx, dx, 128'd0, 1'b1, 0, 1'b1, 66));
    chk("err_cnt_saturated", {120'd0, err_cnt}, 128'd255);

    repeat (5) @(negedge ACLK);
    chk("sb_drained", 128'(sb_q.size()), 128'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/aes_core_sched.md
Name: aes_core_sched

Overview:
- Round-robin scheduler that shares one iterative AES-128 LUT core (fixed ~41-cycle start-to-done latency) between two requesters.
- Sits between the AXI4-Lite slave register front-end (requester 0) and a streaming/DMA front-end (requester 1) on one side, and the AES core on the other.
- Captures key and block, issues start, waits for done under a watchdog, then returns the result to the owning requester with backpressure.

Parameters:
- DATA_W, 128, plaintext/ciphertext width
- KEY_W, 128, key width
- TIMEOUT, 64, cycles to wait in WAIT for core_done before the watchdog fires; must be > core latency and ≤ 2^CNT_W
- CNT_W, 7, watchdog counter width

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  reset
- req0_valid  in  1  requester 0 command valid
- req0_ready  out  1  requester 0 command accepted
- req0_key  in  KEY_W  requester 0 key
- req0_data  in  DATA_W  requester 0 input block
- resp0_valid  out  1  requester 0 result valid
- resp0_ready  in  1  requester 0 result accept
- resp0_data  out  DATA_W  requester 0 result block
- resp0_err  out  1  requester 0 timeout flag
- req1_valid, req1_ready, req1_key, req1_data, resp1_valid, resp1_ready, resp1_data, resp1_err: same as requester 0, for requester 1
- core_start  out  1  one-cycle start pulse to the AES core
- core_key  out  KEY_W  key to the core
- core_din  out  DATA_W  block to the core
- core_done  in  1  core completion pulse
- core_dout  in  DATA_W  core result, valid when core_done=1
- busy  out  1  high whenever state != IDLE
- owner  out  1  index of the current/last granted requester
- err_cnt  out  8  saturating count of watchdog timeouts

Behaviour:
- Single clock ACLK. ARESETN is synchronous, active-low, sampled on the rising edge of ACLK.
- Reset values:
  - state = IDLE
  - all valid, ready, start and err outputs = 0
  - all data/key output registers = 0
  - owner = 1 (so requester 0 wins the first tie)
  - err_cnt = 0
  - watchdog count = 0
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant logic: if only one reqN_valid is high, grant it. If both are high, grant the requester != owner (round-robin).
  - reqN_ready is combinational: (state==IDLE) && granted N. The non-granted requester sees ready=0.
  - On handshake: register key/data into core_key/core_din, set owner=N, go to ISSUE.
  - With no valid, stay in IDLE.
- ISSUE:
  - core_start=1 for exactly this cycle; clear the watchdog count.
  - Go to WAIT.
  - core_key/core_din stay stable from ISSUE until the next IDLE handshake.
- WAIT:
  - Watchdog count increments each cycle.
  - If core_done=1: capture core_dout into resp data, err=0, go to RESP. core_done has priority over timeout in the same cycle.
  - Else if count == TIMEOUT-1: resp data = 0, err=1, err_cnt += 1 (saturates at 255), go to RESP.
- RESP:
  - resp{owner}_valid=1. Data and err are held stable until resp{owner}_ready=1.
  - The other requester's resp_valid stays 0.
  - On handshake, go to IDLE; valid drops the next cycle.
- core_done arriving in IDLE, ISSUE or RESP is ignored; no state change and no capture.
- Latency, for core latency L (start to done):
  - req handshake at cycle T
  - core_start at T+1
  - core_done at T+1+L
  - resp_valid at T+2+L (L=41 gives 43 cycles)
- Throughput: a resp handshake at R returns to IDLE at R+1, where a new request can be accepted. A request presented during RESP waits; no overlap.
- Requester valid may drop before ready without harm (no capture). Granted data is sampled only on the handshake cycle.
- busy = (state != IDLE). owner holds its value after completion.
- Reset mid-operation:
  - The operation is abandoned: no response is issued and core_start=0.
  - The AES core shares ARESETN and is reset with the scheduler.
  - err_cnt clears.

Test Plan:
- Single req0: key=000102...0F, data=00112233445566778899AABBCCDDEEFF, core model latency 41 -> core_start one cycle after accept; resp0_valid 43 cycles after accept; resp0_data=69C4E0D86A7B0430D8CDB78070B4C55A; resp0_err=0; resp1_valid never high.
- req0 and req1 both valid from reset -> req0 granted first, req1 second. Repeat with both held valid for 4 ops -> grant order 0,1,0,1; owner toggles.
- Backpressure: hold resp1_ready=0 for 20 cycles after resp1_valid -> resp1_data/err stable, busy=1, new req0 not accepted (req0_ready=0) until the cycle after the resp1 handshake.
- Watchdog: core model never asserts done, TIMEOUT=64 -> resp0_valid 65 cycles after core_start with resp0_err=1, resp0_data=0, err_cnt=1. After 256 such timeouts err_cnt=255.
- core_done in the same cycle as count == TIMEOUT-1 -> normal result, err=0, err_cnt unchanged. A spurious core_done in IDLE -> no response, state stays IDLE.
- ARESETN low for 1 cycle mid-WAIT -> next cycle: state IDLE, busy=0, all valids 0, owner=1, no response ever issued for the aborted request.
